// File: rtl/mil1553_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a MIL-STD-1553 encoder; zero-latency stream mux while ACTIVE.
// Backpressure: granted tready mirrors m_tready, everyone else held off; enforces an inter-message gap and starvation timeout.
module mil1553_tx_arbiter #(
   parameter int unsigned GAP_CYCLES     = 400,
   parameter int unsigned TIMEOUT_CYCLES = 4000,
   parameter int unsigned MAX_WORDS      = 33
) (
   input  logic        aclk,
   input  logic        rst,
   input  logic [15:0] s0_tdata,
   input  logic [7:0]  s0_tuser,
   input  logic        s0_tvalid,
   input  logic        s0_tlast,
   output logic        s0_tready,
   input  logic [15:0] s1_tdata,
   input  logic [7:0]  s1_tuser,
   input  logic        s1_tvalid,
   input  logic        s1_tlast,
   output logic        s1_tready,
   output logic [15:0] m_tdata,
   output logic [7:0]  m_tuser,
   output logic        m_tvalid,
   output logic        m_tlast,
   input  logic        m_tready,
   output logic [1:0]  grant,
   output logic        busy,
   output logic        abort,
   output logic        overrun
);

   localparam logic [15:0] MAX_LAST = 16'(MAX_WORDS - 1);
   localparam logic [15:0] TO_LIM   = 16'(TIMEOUT_CYCLES);
   localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

   state_t      state_q;
   logic [1:0]  grant_q;
   logic        last_q;      // 1 = s1 was served last
   logic [15:0] word_q, to_q, gap_q;
   logic        abort_q, overrun_q;

   logic        active, g_vld, g_last, hs, end_last, end_to;
   logic [15:0] word_d, to_d;

   assign active  = (state_q == ACTIVE);
   assign g_vld   = grant_q[1] ? s1_tvalid : s0_tvalid;
   assign g_last  = grant_q[1] ? s1_tlast  : s0_tlast;
   assign m_tdata = grant_q[1] ? s1_tdata  : s0_tdata;
   assign m_tuser = grant_q[1] ? s1_tuser  : s0_tuser;
   assign m_tvalid = active & g_vld;
   assign m_tlast  = g_last | (word_q == MAX_LAST);
   assign s0_tready = active & grant_q[0] & m_tready;
   assign s1_tready = active & grant_q[1] & m_tready;

   assign hs       = m_tvalid & m_tready;
   assign word_d   = (word_q == 16'hFFFF) ? word_q : word_q + 16'd1;
   assign to_d     = (to_q == 16'hFFFF) ? to_q : to_q + 16'd1;
   assign end_last = hs & m_tlast;
   // Stalls caused only by m_tready keep g_vld high, so they never reach the timeout.
   assign end_to   = active & ~g_vld & (to_d >= TO_LIM);

   assign grant   = grant_q;
   assign busy    = (state_q != IDLE);
   assign abort   = abort_q;
   assign overrun = overrun_q;

   always_ff @(posedge aclk) begin
      if (rst) begin
         state_q   <= IDLE;
         grant_q   <= 2'b00;
         last_q    <= 1'b1;
         word_q    <= '0;
         to_q      <= '0;
         gap_q     <= '0;
         abort_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         abort_q   <= 1'b0;
         overrun_q <= 1'b0;
         case (state_q)
            IDLE: begin
               word_q <= '0;
               to_q   <= '0;
               if (s0_tvalid || s1_tvalid) begin
                  state_q <= ACTIVE;
                  grant_q <= (s0_tvalid && (!s1_tvalid || last_q)) ? 2'b01 : 2'b10;
               end
            end
            ACTIVE: begin
               if (hs) word_q <= word_d;
               to_q <= g_vld ? '0 : to_d;
               if (end_last || end_to) begin
                  state_q   <= (GAP_CYCLES == 0) ? IDLE : GAP;
                  grant_q   <= 2'b00;
                  last_q    <= grant_q[1];
                  gap_q     <= '0;
                  abort_q   <= end_to;
                  overrun_q <= end_last & ~g_last;
               end
            end
            GAP: begin
               if (gap_q >= GAP_LAST) state_q <= IDLE;
               else                   gap_q   <= gap_q + 16'd1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
